// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - opcode constants and FSM state encoding for the accumulator CPU
package acc_cpu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_LDI = 4'h1;
    localparam logic [OPW-1:0] OP_ADD = 4'h2;
    localparam logic [OPW-1:0] OP_ADC = 4'h3;
    localparam logic [OPW-1:0] OP_SUB = 4'h4;
    localparam logic [OPW-1:0] OP_AND = 4'h5;
    localparam logic [OPW-1:0] OP_OR  = 4'h6;
    localparam logic [OPW-1:0] OP_XOR = 4'h7;
    localparam logic [OPW-1:0] OP_JMP = 4'h8;
    localparam logic [OPW-1:0] OP_JC  = 4'h9;
    localparam logic [OPW-1:0] OP_JNC = 4'hA;
    localparam logic [OPW-1:0] OP_CLC = 4'hB;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational ALU; non-arithmetic opcodes pass the accumulator and carry through
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic           cin,
    output logic [DW-1:0]  y,
    output logic           cout
);

    logic [DW:0] sum;

    // result and carry per opcode; the extra MSB of sum is the carry (or borrow for SUB)
    always_comb begin
        sum  = '0;
        y    = a;
        cout = cin;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                y    = sum[DW-1:0];
                cout = sum[DW];
            end
            OP_ADC: begin
                sum  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
                y    = sum[DW-1:0];
                cout = sum[DW];
            end
            OP_SUB: begin
                sum  = {1'b0, a} - {1'b0, b};
                y    = sum[DW-1:0];
                cout = sum[DW];
            end
            OP_AND:  y    = a & b;
            OP_OR:   y    = a | b;
            OP_XOR:  y    = a ^ b;
            OP_CLC:  cout = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_p.sv
// rtl/acc_cpu_p.sv - two-cycle accumulator CPU with a writable program store
module acc_cpu_p
    import acc_cpu_pkg::*;
#(
    parameter  int DW = 4,
    parameter  int PW = 3,
    localparam int IW = OPW + PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [DW-1:0] mux_in_data,
    input  logic [DW-1:0] alu_in_data,
    output logic [PW-1:0] pc_out,
    output logic [IW-1:0] rom_out,
    output logic [DW-1:0] reg_out,
    output logic [DW-1:0] alu_out,
    output logic          carry_out,
    output logic          halted
);

    localparam int DEPTH = 2**PW;

    logic [IW-1:0]  mem [DEPTH];
    state_t         state;
    state_t         state_nxt;
    logic [OPW-1:0] opcode;
    logic [PW-1:0]  target;
    logic           jump_taken;
    logic [DW-1:0]  alu_y;
    logic           alu_cout;

    assign opcode  = rom_out[IW-1:PW];
    assign target  = rom_out[PW-1:0];
    assign halted  = (state == ST_HALT);
    assign alu_out = alu_y;

    acc_alu #(.DW(DW)) u_alu (
        .op   (opcode),
        .a    (reg_out),
        .b    (alu_in_data),
        .cin  (carry_out),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // branch decision from the instruction register and current carry
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JC:   jump_taken = carry_out;
            OP_JNC:  jump_taken = ~carry_out;
            default: jump_taken = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: HALT waits for run, FETCH/EXEC alternate until HLT executes
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT:  if (run) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
            default:  state_nxt = ST_HALT;
        endcase
    end

    // program store: writable only while halted, cleared to NOP by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_HALT && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // datapath: FETCH loads the instruction register, EXEC commits accumulator, carry and PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out    <= '0;
            rom_out   <= '0;
            reg_out   <= '0;
            carry_out <= 1'b0;
        end else if (state == ST_FETCH) begin
            rom_out <= mem[pc_out];
        end else if (state == ST_EXEC) begin
            case (opcode)
                OP_LDI:                                        reg_out <= mux_in_data;
                OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: reg_out <= alu_y;
                default: ;
            endcase
            carry_out <= alu_cout;
            if (opcode == OP_HLT) begin
                pc_out <= pc_out;
            end else if (jump_taken) begin
                pc_out <= target;
            end else begin
                pc_out <= pc_out + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_cpu_p.sv
// tb/tb_acc_cpu_p.sv - scoreboard bench for acc_cpu_p with an instruction-level reference model
module tb_acc_cpu_p;

    localparam int DW = 4;
    localparam int PW = 3;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [DW-1:0] mux_in_data = '0;
    logic [DW-1:0] alu_in_data = '0;
    logic [PW-1:0] pc_out;
    logic [IW-1:0] rom_out;
    logic [DW-1:0] reg_out;
    logic [DW-1:0] alu_out;
    logic          carry_out;
    logic          halted;

    acc_cpu_p #(.DW(DW), .PW(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .mux_in_data (mux_in_data),
        .alu_in_data (alu_in_data),
        .pc_out      (pc_out),
        .rom_out     (rom_out),
        .reg_out     (reg_out),
        .alu_out     (alu_out),
        .carry_out   (carry_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int rom;
        int rg;
        int c;
        int h;
        int alu;
    } rec_t;

    rec_t q[$];
    int   vectors = 0;
    int   fails = 0;

    logic [IW-1:0] prog [8];
    int m_pc, m_r, m_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] ins(input int op, input int t);
        logic [3:0] o4;
        logic [2:0] t3;
        o4 = op[3:0];
        t3 = t[2:0];
        return {o4, t3};
    endfunction

    // instruction-level model: executes up to limit instructions from the model state
    task automatic build_expect(input int limit);
        int op, tgt, res, nc, b, oldc;
        rec_t e;
        b = int'(alu_in_data);
        for (int n = 0; n < limit; n++) begin
            op   = int'(prog[m_pc][6:3]);
            tgt  = int'(prog[m_pc][2:0]);
            oldc = m_c;
            res  = m_r;
            nc   = m_c;
            case (op)
                2: begin res = m_r + b;        nc = (res > 15) ? 1 : 0; res = res % 16; end
                3: begin res = m_r + b + m_c;  nc = (res > 15) ? 1 : 0; res = res % 16; end
                4: begin nc = (m_r < b) ? 1 : 0; res = (m_r - b + 16) % 16; end
                5: res = m_r & b;
                6: res = m_r | b;
                7: res = m_r ^ b;
                11: nc = 0;
                default: ;
            endcase
            e.alu = res;
            e.rom = int'(prog[m_pc]);
            if (op == 1) m_r = int'(mux_in_data);
            else if (op >= 2 && op <= 7) m_r = res;
            m_c = nc;
            if (op == 15) ;
            else if (op == 8 || (op == 9 && oldc == 1) || (op == 10 && oldc == 0)) m_pc = tgt;
            else m_pc = (m_pc + 1) % 8;
            e.pc = m_pc;
            e.rg = m_r;
            e.c  = m_c;
            e.h  = (op == 15) ? 1 : 0;
            q.push_back(e);
            if (op == 15) break;
        end
    endtask

    // monitor: infers FETCH/EXEC from the halted flag and the fixed two-cycle rhythm
    initial begin
        int   phase;
        int   nphase;
        rec_t e;
        phase = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
                continue;
            end
            if (phase == 2) begin
                if (q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_retire: got retire at pc %0d expected none", pc_out);
                end else begin
                    e = q.pop_front();
                    chk("ret_pc", 32'(pc_out), e.pc);
                    chk("ret_reg", 32'(reg_out), e.rg);
                    chk("ret_carry", 32'(carry_out), e.c);
                    chk("ret_halted", 32'(halted), e.h);
                    chk("ret_rom", 32'(rom_out), e.rom);
                end
            end
            if (halted) nphase = 0;
            else if (phase == 1) nphase = 2;
            else nphase = 1;
            if (nphase == 2 && q.size() > 0) begin
                chk("exec_alu_out", 32'(alu_out), q[0].alu);
                chk("exec_rom_out", 32'(rom_out), q[0].rom);
            end
            phase = nphase;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        run = 1'b0;
        prog_we = 1'b0;
        #1;
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_rom", 32'(rom_out), 0);
        chk("rst_reg", 32'(reg_out), 0);
        chk("rst_carry", 32'(carry_out), 0);
        chk("rst_halted", 32'(halted), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = 0; m_r = 0; m_c = 0;
        for (int i = 0; i < 8; i++) prog[i] = '0;
    endtask

    // writes words 7..0; run is raised together with the write of word 0
    task automatic load_and_run();
        for (int a = 7; a >= 0; a--) begin
            @(posedge clk); #1;
            prog_we   = 1'b1;
            prog_addr = PW'(a);
            prog_data = prog[a];
            run       = (a == 0);
        end
        @(posedge clk); #1;
        prog_we = 1'b0;
        run     = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL timeout: got %0d pending retires expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        m_pc = 0; m_r = 0; m_c = 0;
        for (int i = 0; i < 8; i++) prog[i] = '0;
        repeat (2) @(posedge clk);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_halted", 32'(halted), 1);
        chk("idle_pc", 32'(pc_out), 0);

        // LDI, ADD, ADD, HLT
        prog[0] = ins(1, 0); prog[1] = ins(2, 0); prog[2] = ins(2, 0); prog[3] = ins(15, 0);
        mux_in_data = 4'b0101; alu_in_data = 4'b0001;
        build_expect(10);
        load_and_run();
        wait_done();
        #1;
        chk("p1_reg", 32'(reg_out), 32'b0111);
        chk("p1_pc", 32'(pc_out), 3);
        chk("p1_halted", 32'(halted), 1);

        // LDI, ADD, JC 6, ..., HLT at 6
        do_reset();
        prog[0] = ins(1, 0); prog[1] = ins(2, 0); prog[2] = ins(9, 6); prog[6] = ins(15, 0);
        mux_in_data = 4'b1111; alu_in_data = 4'b0001;
        build_expect(10);
        load_and_run();
        wait_done();
        #1;
        chk("p2_reg", 32'(reg_out), 0);
        chk("p2_carry", 32'(carry_out), 1);
        chk("p2_pc", 32'(pc_out), 6);

        // all NOP with wrap, writes attempted while running must be ignored
        do_reset();
        mux_in_data = 4'b0011; alu_in_data = 4'b0110;
        build_expect(12);
        load_and_run();
        prog_we = 1'b1; prog_addr = 3'd3; prog_data = ins(15, 0);
        wait_done();
        #1;
        chk("p3_running", 32'(halted), 0);
        chk("p3_pc", 32'(pc_out), 4);

        // SUB borrow, then resume at the HLT address with ADC and CLC
        do_reset();
        prog[0] = ins(1, 0); prog[1] = ins(4, 0); prog[2] = ins(15, 0);
        mux_in_data = 4'b0001; alu_in_data = 4'b0010;
        build_expect(10);
        load_and_run();
        wait_done();
        #1;
        chk("sub_reg", 32'(reg_out), 32'b1111);
        chk("sub_carry", 32'(carry_out), 1);
        prog[2] = ins(1, 0); prog[3] = ins(3, 0); prog[4] = ins(11, 0); prog[5] = ins(15, 0);
        alu_in_data = 4'b0001;
        build_expect(10);
        load_and_run();
        wait_done();
        #1;
        chk("adc_clc_reg", 32'(reg_out), 32'b0011);
        chk("clc_carry", 32'(carry_out), 0);

        // reset asserted during EXEC of ADD
        do_reset();
        prog[0] = ins(1, 0); prog[1] = ins(2, 0); prog[2] = ins(15, 0);
        mux_in_data = 4'b0101; alu_in_data = 4'b1111;
        build_expect(1);
        load_and_run();
        wait_done();
        #1;
        rst = 1'b1;
        #1;
        chk("abort_reg", 32'(reg_out), 0);
        chk("abort_carry", 32'(carry_out), 0);
        chk("abort_halted", 32'(halted), 1);
        chk("abort_pc", 32'(pc_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // randomized programs
        for (int t = 0; t < 30; t++) begin
            do_reset();
            for (int i = 0; i < 8; i++) prog[i] = ins($urandom_range(0, 15), $urandom_range(0, 7));
            mux_in_data = DW'($urandom_range(0, 15));
            alu_in_data = DW'($urandom_range(0, 15));
            build_expect(16);
            load_and_run();
            wait_done();
        end

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
